alu_muldiv: RTL and testbench

Multi-cycle integer multiply/divide unit: the sequential companion to the single-cycle `alu` in the execute stage. It implements the eight RV32M operations over a parametrised `WIDTH`. Each operation is computed iteratively, one bit per clock, behind a valid/ready handshake so the core control can stall on it. It has the same `result`/`zero` outputs as `alu`, so writeback selects between the two with a single mux.

---
 rtl/alu_muldiv.sv | 215 +++++++++++++++++++++
 tb/tb_alu_muldiv.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative RV32M multiply/divide unit, one result bit per clock.
//
// Companion to the single-cycle alu. It has the same result/zero outputs, so
// writeback can select between the two units with one mux.
//
// Parameters:
//   WIDTH      operand/result width (>= 4)
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset; aborts any operation in flight
//   in_valid   request strobe
//   in_ready   high only in IDLE; decoded from registered state only
//   a, b       operands (a = dividend, b = divisor for divide ops)
//   op         RV32M funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   out_valid  result valid (DONE state); decoded from registered state only
//   out_ready  consumer takes the result
//   result     registered result, held until the next write
//   zero       result == 0
//
// Configuration macro:
//   ALU_MULDIV_DIV_EN  when defined, the restoring divider and the divide
//                      special cases are built in. When undefined, divide ops
//                      complete in one cycle with result 0.

module alu_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int unsigned CntW    = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  // Registered state
  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  // Multiply: {partial product high, multiplier shifting out}.
  // Divide:   {partial remainder, dividend shifting into quotient}.
  // Special case: low half carries the precomputed result.
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opb_q, opb_d;      // multiplicand or divisor magnitude
  logic [2:0]           op_q, op_d;
  logic                 neg_q, neg_d;      // negate the unsigned core result
  logic                 special_q, special_d;
  logic [WIDTH-1:0]     result_q, result_d;

  // Accept-time decode of the incoming request
  logic                 signed_a, signed_b;
  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic                 special;
  logic [WIDTH-1:0]     special_res;

  always_comb begin
    signed_a = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    signed_b = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    a_neg    = signed_a & a[WIDTH-1];
    b_neg    = signed_b & b[WIDTH-1];
    // The most-negative value maps onto itself, which is its correct unsigned magnitude.
    a_mag    = a_neg ? (~a + WIDTH'(1)) : a;
    b_mag    = b_neg ? (~b + WIDTH'(1)) : b;
`ifdef ALU_MULDIV_DIV_EN
    special     = 1'b0;
    special_res = '0;
    if (op[2]) begin
      if (b == '0) begin
        special     = 1'b1;
        special_res = op[1] ? a : '1;
      end else if (!op[0] && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (&b)) begin
        // Signed overflow: most-negative / -1
        special     = 1'b1;
        special_res = op[1] ? '0 : a;
      end
    end
`else
    special     = op[2];
    special_res = '0;
`endif
  end

  // One shift-add multiply step
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_acc;

  always_comb begin
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_acc = {mul_sum, acc_q[WIDTH-1:1]};
  end

`ifdef ALU_MULDIV_DIV_EN
  // One restoring-division step
  logic [WIDTH:0]       rem_sh;
  logic                 rem_ge;
  logic [WIDTH-1:0]     rem_diff;
  logic [2*WIDTH-1:0]   div_acc;

  always_comb begin
    rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    rem_ge   = rem_sh >= {1'b0, opb_q};
    // The true difference is below the divisor, so WIDTH bits suffice.
    rem_diff = rem_sh[WIDTH-1:0] - opb_q;
    div_acc  = {(rem_ge ? rem_diff : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], rem_ge};
  end
`endif

  // Step selection and final sign correction
  logic [2*WIDTH-1:0]   step_acc;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     mul_res;
  logic [WIDTH-1:0]     fin_res;
`ifdef ALU_MULDIV_DIV_EN
  logic [WIDTH-1:0]     div_val;
  logic [WIDTH-1:0]     div_res;
`endif

  always_comb begin
    prod    = neg_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
    mul_res = (op_q[1:0] != 2'b00) ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
`ifdef ALU_MULDIV_DIV_EN
    step_acc = op_q[2] ? div_acc : mul_acc;
    div_val  = op_q[1] ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0];
    div_res  = neg_q ? (~div_val + WIDTH'(1)) : div_val;
    fin_res  = op_q[2] ? div_res : mul_res;
`else
    step_acc = mul_acc;
    // Divide ops always take the special path in this build.
    fin_res  = op_q[2] ? '0 : mul_res;
`endif
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    op_d      = op_q;
    neg_d     = neg_q;
    special_d = special_q;
    result_d  = result_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d   = StCalc;
          cnt_d     = '0;
          acc_d     = {{WIDTH{1'b0}}, (special ? special_res : a_mag)};
          opb_d     = b_mag;
          op_d      = op;
          // Remainder follows the dividend; products and quotients use the XOR.
          neg_d     = (op[2] & op[1]) ? a_neg : (a_neg ^ b_neg);
          special_d = special;
        end
      end
      StCalc: begin
        if (special_q) begin
          result_d = acc_q[WIDTH-1:0];
          state_d  = StDone;
        end else if (cnt_q == LastCnt) begin
          result_d = fin_res;
          state_d  = StDone;
        end else begin
          acc_d = step_acc;
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      special_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      special_q <= special_d;
      result_q  <= result_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign result    = result_q;
  assign zero      = (result_q == '0);

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv at WIDTH=32: directed table, handshake
// corner sequences, asynchronous reset abort and randomized ops against a
// plain-arithmetic reference model.

module tb_alu_muldiv;

  localparam int unsigned W = 32;
`ifdef ALU_MULDIV_DIV_EN
  localparam bit DivEn = 1'b1;
`else
  localparam bit DivEn = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [2:0]    op;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          zero;

  alu_muldiv #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference model: RV32M semantics with 64-bit integer arithmetic.
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x,
                                        input logic [31:0] y);
    int          ix, iy;
    longint      sx, sy;
    logic [63:0] ux, uy, p;
    ix = x;
    iy = y;
    sx = ix;
    sy = iy;
    ux = {32'b0, x};
    uy = {32'b0, y};
    p  = '0;
    if (o[2] && !DivEn) return 32'h0;
    case (o)
      3'd0: p = sx * sy;
      3'd1: p = sx * sy;
      3'd2: p = sx * longint'(uy);
      3'd3: p = ux * uy;
      3'd4: p = (y == 0) ? 64'hFFFF_FFFF : sx / sy;
      3'd5: p = (y == 0) ? 64'hFFFF_FFFF : ux / uy;
      3'd6: p = (y == 0) ? ux : sx % sy;
      default: p = (y == 0) ? ux : ux % uy;
    endcase
    if (o == 3'd1 || o == 3'd2 || o == 3'd3) return p[63:32];
    return p[31:0];
  endfunction

  function automatic int lat_of(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    if (!o[2]) return W + 1;
    if (!DivEn) return 1;
    if (y == 0) return 1;
    if ((o == 3'd4 || o == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
    return W + 1;
  endfunction

  // Issue one op from IDLE, measure latency, check result/zero, then hand off.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp, input int lat, input string name);
    int cyc;
    cyc = 0;
    while (!in_ready && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({name, " in_ready"}, {31'b0, in_ready}, 32'd1);
    a        = x;
    b        = y;
    op       = o;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
    op       = 3'($urandom_range(0, 7));
    cyc      = 0;
    while (!out_valid && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({name, " result"}, result, exp);
    check({name, " zero"}, {31'b0, zero}, {31'b0, (exp == 32'h0)});
    check({name, " latency"}, 32'(cyc), 32'(lat));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  localparam int NTbl = 16;
  vec_t tbl [NTbl];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    logic [2:0]  o;
    logic [31:0] x, y;

    tbl[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
    tbl[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33};
    tbl[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    tbl[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
    tbl[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33};
    tbl[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33};
    tbl[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        33};
    tbl[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         33};
    tbl[8]  = '{3'd7, 32'd14,         32'd7,         32'd0,         33};
    tbl[9]  = '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
    tbl[10] = '{3'd7, 32'd5,          32'd0,         32'd5,         1};
    tbl[11] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
    tbl[12] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};
    tbl[13] = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
    tbl[14] = '{3'd6, 32'd5,          32'd0,         32'd5,         1};
    tbl[15] = '{3'd5, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         33};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    op        = '0;
    #12;
    check("reset in_ready", {31'b0, in_ready}, 32'd1);
    check("reset out_valid", {31'b0, out_valid}, 32'd0);
    check("reset result", result, 32'h0);
    check("reset zero", {31'b0, zero}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed table
    for (int i = 0; i < NTbl; i++) begin
      logic [31:0] e;
      int          l;
      e = tbl[i].exp;
      l = tbl[i].lat;
      if (tbl[i].op[2] && !DivEn) begin
        e = 32'h0;
        l = 1;
      end
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, e, l, $sformatf("tbl%0d", i));
    end

    // Backpressure: held result, no second accept while a request is pending
    a        = 32'd6;
    b        = 32'd7;
    op       = 3'd0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    a  = 32'hFFFF_FFFF;
    b  = 32'hFFFF_FFFF;
    op = 3'd3;
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("bp first latency", 32'(cyc), 32'd33);
    for (int i = 0; i < 10; i++) begin
      check("bp out_valid", {31'b0, out_valid}, 32'd1);
      check("bp in_ready", {31'b0, in_ready}, 32'd0);
      check("bp result", result, 32'd42);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp release in_ready", {31'b0, in_ready}, 32'd1);
    check("bp release out_valid", {31'b0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp second accepted", {31'b0, in_ready}, 32'd0);
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("bp second latency", 32'(cyc), 32'd33);
    check("bp second result", result, 32'hFFFF_FFFE);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    // Asynchronous reset in the middle of a DIVU
    a        = 32'd100;
    b        = 32'd7;
    op       = 3'd5;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort out_valid", {31'b0, out_valid}, 32'd0);
    check("abort in_ready", {31'b0, in_ready}, 32'd1);
    check("abort result", result, 32'h0);
    check("abort zero", {31'b0, zero}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_op(3'd0, 32'd3, 32'd4, 32'd12, 33, "post-reset mul");

    // Randomized ops against the reference model
    for (int i = 0; i < 150; i++) begin
      o = 3'($urandom_range(0, 7));
      x = pick();
      y = pick();
      run_op(o, x, y, model(o, x, y), lat_of(o, x, y), $sformatf("rnd%0d op%0d", i, o));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
